// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

   // Scan FSM: all-off gap, lit digit, or display disabled
   typedef enum logic [1:0] {
      BLANK = 2'd0,
      SHOW  = 2'd1,
      OFF   = 2'd2
   } scan_state_t;

   typedef logic [1:0] digit_idx_t;

   localparam digit_idx_t IDX_ONES      = 2'd0;
   localparam digit_idx_t IDX_TENS      = 2'd1;
   localparam digit_idx_t IDX_HUNDREDS  = 2'd2;
   localparam digit_idx_t IDX_THOUSANDS = 2'd3;

   localparam logic [3:0] DIGIT_OFF = 4'b1111;
   localparam logic [7:0] SEG_OFF   = 8'hFF;

   // Active-low digit selects
   localparam logic [3:0] SEL_ONES      = 4'b1110;
   localparam logic [3:0] SEL_TENS      = 4'b1101;
   localparam logic [3:0] SEL_HUNDREDS  = 4'b1011;
   localparam logic [3:0] SEL_THOUSANDS = 4'b0111;

   function automatic logic [3:0] digit_select(input digit_idx_t idx);
      logic [3:0] sel;
      case (idx)
         IDX_ONES:      sel = SEL_ONES;
         IDX_TENS:      sel = SEL_TENS;
         IDX_HUNDREDS:  sel = SEL_HUNDREDS;
         default:       sel = SEL_THOUSANDS;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low 7-segment glyph; bit7 is the decimal point, held off.
// Latency: combinational.
// Backpressure: none.
module seg_decoder (
   input  logic [3:0] digit_i,
   output logic [7:0] seg_o
);

   // One distinct glyph per hex value, segments {dp,g,f,e,d,c,b,a} active low
   always_comb begin
      seg_o = 8'hFF;
      case (digit_i)
         4'h0: seg_o = 8'hC0;
         4'h1: seg_o = 8'hF9;
         4'h2: seg_o = 8'hA4;
         4'h3: seg_o = 8'hB0;
         4'h4: seg_o = 8'h99;
         4'h5: seg_o = 8'h92;
         4'h6: seg_o = 8'h82;
         4'h7: seg_o = 8'hF8;
         4'h8: seg_o = 8'h80;
         4'h9: seg_o = 8'h90;
         4'hA: seg_o = 8'h88;
         4'hB: seg_o = 8'h83;
         4'hC: seg_o = 8'hC6;
         4'hD: seg_o = 8'hA1;
         4'hE: seg_o = 8'h86;
         4'hF: seg_o = 8'h8E;
         default: seg_o = 8'hFF;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed display scanner with blanking gaps and frame-aligned loads.
// Latency: controlOut/segOut/frameStart registered; loadAck is combinational in the commit cycle.
// Backpressure: none; loads overwrite staging until the next frame commit (LEADING_ZERO_BLANK_EN optional).
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        displayClock,
   input  logic        reset,
   input  logic        enableIn,
   input  logic        loadIn,
   input  logic [15:0] digitsIn,
   output logic        loadAck,
   output logic        frameStart,
   output logic [3:0]  controlOut,
   output logic [7:0]  segOut
);

   localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   scan_state_t   state_q, state_d;
   digit_idx_t    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   disp_q, disp_d;
   logic [15:0]   stage_q, stage_d;
   logic          pend_q, pend_d;
   logic [3:0]    ctrl_q, ctrl_d;
   logic [7:0]    seg_q, seg_d;
   logic          frame_q, frame_d;
   logic          ack_c;
   logic [3:0]    digit_mux;
   logic          lead_zero;
   logic [7:0]    seg_dec;
   logic          scan_commit;

   // Segment timing: count out BLANK/SHOW, advance digit, drop to OFF only at a segment end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + CW'(1);
      case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d = '0;
               if (enableIn) begin
                  state_d = SHOW;
               end else begin
                  state_d = OFF;
                  idx_d   = IDX_ONES;
               end
            end
         end
         SHOW: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d = '0;
               if (enableIn) begin
                  state_d = BLANK;
                  idx_d   = idx_q + 2'd1;
               end else begin
                  state_d = OFF;
                  idx_d   = IDX_ONES;
               end
            end
         end
         OFF: begin
            cnt_d = '0;
            if (enableIn) begin
               state_d = BLANK;
               idx_d   = IDX_ONES;
            end
         end
         default: begin
            state_d = BLANK;
            idx_d   = IDX_ONES;
            cnt_d   = '0;
         end
      endcase
   end

   assign scan_commit = (state_q == BLANK) && (idx_q == IDX_ONES) && (cnt_q == '0);

   // Load staging and commit: frame boundary commits (with bypass), OFF commits one cycle after capture
   always_comb begin
      disp_d  = disp_q;
      stage_d = stage_q;
      pend_d  = pend_q;
      ack_c   = 1'b0;
      if (scan_commit) begin
         // A load arriving on the commit cycle goes straight to the display and shares the ack
         if (loadIn) begin
            disp_d  = digitsIn;
            stage_d = digitsIn;
            ack_c   = 1'b1;
         end else if (pend_q) begin
            disp_d = stage_q;
            ack_c  = 1'b1;
         end
         pend_d = 1'b0;
      end else begin
         if ((state_q == OFF) && pend_q) begin
            disp_d = stage_q;
            pend_d = 1'b0;
            ack_c  = 1'b1;
         end
         if (loadIn) begin
            stage_d = digitsIn;
            pend_d  = 1'b1;
         end
      end
   end

   // Select the nibble for the next lit digit and decide leading-zero suppression
   always_comb begin
      digit_mux = disp_d[3:0];
      lead_zero = 1'b0;
      case (idx_d)
         IDX_ONES:      digit_mux = disp_d[3:0];
         IDX_TENS:      digit_mux = disp_d[7:4];
         IDX_HUNDREDS:  digit_mux = disp_d[11:8];
         IDX_THOUSANDS: digit_mux = disp_d[15:12];
         default:       digit_mux = disp_d[3:0];
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      case (idx_d)
         IDX_TENS:      lead_zero = (disp_d[15:4] == 12'h000);
         IDX_HUNDREDS:  lead_zero = (disp_d[15:8] == 8'h00);
         IDX_THOUSANDS: lead_zero = (disp_d[15:12] == 4'h0);
         default:       lead_zero = 1'b0;
      endcase
`else
      lead_zero = 1'b0;
`endif
   end

   seg_decoder u_seg_decoder (
      .digit_i (digit_mux),
      .seg_o   (seg_dec)
   );

   // Outputs are built from next-state so select and segments land on the same edge
   always_comb begin
      ctrl_d  = DIGIT_OFF;
      seg_d   = SEG_OFF;
      frame_d = 1'b0;
      if (state_d == SHOW) begin
         ctrl_d  = digit_select(idx_d);
         seg_d   = lead_zero ? SEG_OFF : seg_dec;
         frame_d = (idx_d == IDX_ONES) && (cnt_d == '0);
      end
   end

   // State, data and output registers
   always_ff @(posedge displayClock or posedge reset) begin
      if (reset) begin
         state_q <= BLANK;
         idx_q   <= IDX_ONES;
         cnt_q   <= '0;
         disp_q  <= '0;
         stage_q <= '0;
         pend_q  <= 1'b0;
         ctrl_q  <= DIGIT_OFF;
         seg_q   <= SEG_OFF;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         stage_q <= stage_d;
         pend_q  <= pend_d;
         ctrl_q  <= ctrl_d;
         seg_q   <= seg_d;
         frame_q <= frame_d;
      end
   end

   // The reset state sits on a commit cycle, so the ack is masked while reset is held
   assign loadAck    = ack_c & ~reset;
   assign frameStart = frame_q;
   assign controlOut = ctrl_q;
   assign segOut     = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

   localparam int D      = 4;
   localparam int B      = 2;
   localparam int SEGLEN = B + D;
   localparam int FRAME  = 4 * SEGLEN;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic        ld  = 1'b0;
   logic [15:0] din = 16'h0000;
   logic        ack, fs;
   logic [3:0]  ctrl;
   logic [7:0]  seg;

   int n_vec = 0;
   int n_err = 0;
   int ack_seen = 0;

   display_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .displayClock (clk),
      .reset        (rst),
      .enableIn     (en),
      .loadIn       (ld),
      .digitsIn     (din),
      .loadAck      (ack),
      .frameStart   (fs),
      .controlOut   (ctrl),
      .segOut       (seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Reference glyphs written active-high (gfedcba), inverted for the active-low pins
   function automatic logic [7:0] glyph(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
         4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
         4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
         4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
      endcase
      return ~{1'b0, p};
   endfunction

   // Model: position within a 24-clock frame plus an off flag; each digit slot is B blank then D lit
   bit          m_off   = 1'b0;
   int          m_pos   = 0;
   logic [15:0] m_disp  = 16'h0;
   logic [15:0] m_stage = 16'h0;
   bit          m_pend  = 1'b0;
   int          m_w;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_off = 1'b0; m_pos = 0; m_disp = 16'h0; m_stage = 16'h0; m_pend = 1'b0;
      end else begin
         m_w = m_pos % SEGLEN;
         if (!m_off && m_pos == 0) begin
            if (ld) m_disp = din;
            else if (m_pend) m_disp = m_stage;
            m_pend = 1'b0;
         end else begin
            if (m_off && m_pend) begin
               m_disp = m_stage;
               m_pend = 1'b0;
            end
            if (ld) begin
               m_stage = din;
               m_pend  = 1'b1;
            end
         end
         if (m_off) begin
            if (en) begin
               m_off = 1'b0;
               m_pos = 0;
            end
         end else if ((m_w == B - 1 || m_w == SEGLEN - 1) && !en) begin
            m_off = 1'b1;
         end else begin
            m_pos = (m_pos + 1) % FRAME;
         end
      end
   end

   // Every-cycle comparison, sampled mid-low-phase
   int         c_w, c_dig;
   bit         c_lit, c_fs, c_ack;
   logic [3:0] c_onehot, c_ctrl;
   logic [7:0] c_seg;

   always @(negedge clk) begin
      #2;
      c_w   = m_pos % SEGLEN;
      c_dig = m_pos / SEGLEN;
      c_lit = !rst && !m_off && (c_w >= B);
      c_onehot = 4'b0001 << c_dig;
      c_ctrl = c_lit ? ~c_onehot : 4'hF;
      c_seg  = glyph(m_disp[4*c_dig +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (c_dig > 0 && (m_disp >> (4 * c_dig)) == 16'h0) c_seg = 8'hFF;
`endif
      if (!c_lit) c_seg = 8'hFF;
      c_fs  = c_lit && c_dig == 0 && c_w == B;
      c_ack = !rst && ((!m_off && m_pos == 0 && (m_pend || ld)) || (m_off && m_pend));
      check("controlOut", ctrl, c_ctrl);
      check("segOut", seg, c_seg);
      check("frameStart", fs, c_fs);
      check("loadAck", ack, c_ack);
      if (ack === 1'b1) ack_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ctrl(input logic [3:0] want, input string name);
      int k;
      k = 0;
      while (ctrl !== want && k < 200) begin
         @(negedge clk); #3;
         k++;
      end
      check(name, ctrl, want);
   endtask

   task automatic wait_fs(output int k);
      k = 0;
      do begin
         @(negedge clk); #3;
         k++;
      end while (fs !== 1'b1 && k < 100);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   logic [15:0] vals [3] = '{16'h89AB, 16'hCDEF, 16'h5670};

   initial begin
      int k, a0;
      // Reset: a load while reset is held must not ack
      cyc(2);
      ld = 1'b1; din = 16'hBEEF;
      #3 check("ack_in_reset", ack, 0);
      check("ctrl_in_reset", ctrl, 4'hF);
      check("seg_in_reset", seg, 8'hFF);

      // Release with a load on the first (commit) cycle: bypass straight to display
      @(negedge clk); rst = 1'b0; en = 1'b1; ld = 1'b1; din = 16'h1234;
      #3 check("ack_first_cycle", ack, 1);
      @(negedge clk); ld = 1'b0;
      @(negedge clk); #3;
      check("first_lit_ctrl", ctrl, 4'b1110);
      check("first_lit_seg", seg, 8'h99);
      check("first_lit_fs", fs, 1);
      cyc(6); #3;
      check("tens_ctrl", ctrl, 4'b1101);
      check("tens_seg", seg, 8'hB0);
      wait_fs(k);
      wait_fs(k);
      check("frame_period", k, FRAME);

      // Load mid-tens: held until the pre-ones BLANK, ack there, frameStart two later
      wait_ctrl(4'b1101, "wait_tens");
      @(negedge clk); ld = 1'b1; din = 16'h0042;
      k = 0;
      do begin
         @(negedge clk); ld = 1'b0; #3;
         k++;
      end while (ack !== 1'b1 && k < 100);
      check("ack_latency", k, 15);
      check("ack_blank_ctrl", ctrl, 4'hF);
      cyc(2); #3;
      check("fs_after_ack", fs, 1);
      check("seg_after_ack", seg, 8'hA4);

      // Two loads in one frame: one ack, last value wins
      a0 = ack_seen;
      @(negedge clk); ld = 1'b1; din = 16'h1111;
      @(negedge clk); ld = 1'b0;
      cyc(6); ld = 1'b1; din = 16'h2222;
      @(negedge clk); ld = 1'b0;
      cyc(15); #3;
      check("double_load_acks", ack_seen - a0, 1);
      check("double_load_fs", fs, 1);
      check("double_load_seg", seg, 8'hA4);

      // Load on the commit cycle, without and then with a pending load
      a0 = ack_seen;
      cyc(22); ld = 1'b1; din = 16'h5678;
      #3 check("bypass_ack", ack, 1);
      @(negedge clk); ld = 1'b0;
      @(negedge clk); ld = 1'b1; din = 16'h9ABC;
      @(negedge clk); ld = 1'b0;
      cyc(21); ld = 1'b1; din = 16'hDEF0;
      @(negedge clk); ld = 1'b0;
      @(negedge clk); #3;
      check("bypass_ack_count", ack_seen - a0, 2);
      check("bypass_seg", seg, 8'hC0);

      // Disable during hundreds SHOW: finish it, go dark, ack OFF load next cycle, resume at ones
      wait_ctrl(4'b1011, "wait_hundreds");
      @(negedge clk); en = 1'b0;
      cyc(2); #3 check("hundreds_completes", ctrl, 4'b1011);
      @(negedge clk); #3;
      check("off_ctrl", ctrl, 4'hF);
      check("off_seg", seg, 8'hFF);
      cyc(2); ld = 1'b1; din = 16'h4321;
      #3 check("off_load_no_ack_yet", ack, 0);
      @(negedge clk); ld = 1'b0;
      #3 check("off_ack_next", ack, 1);
      cyc(2); en = 1'b1;
      @(negedge clk); #3 check("resume_blank", ctrl, 4'hF);
      cyc(2); #3;
      check("resume_ones_ctrl", ctrl, 4'b1110);
      check("resume_fs", fs, 1);
      check("resume_seg", seg, 8'hF9);

      // Glyph coverage across all hex values
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); ld = 1'b1; din = vals[i];
         @(negedge clk); ld = 1'b0;
         cyc(50);
      end

      // Leading zeros: suppressed only with the blanking option
      @(negedge clk); ld = 1'b1; din = 16'h0007;
      @(negedge clk); ld = 1'b0;
      cyc(50);
      wait_ctrl(4'b0111, "wait_thousands");
`ifdef LEADING_ZERO_BLANK_EN
      check("lz_thousands", seg, 8'hFF);
`else
      check("lz_thousands", seg, 8'hC0);
`endif
      wait_ctrl(4'b1110, "wait_ones_7");
      check("ones_7", seg, 8'hF8);
      @(negedge clk); ld = 1'b1; din = 16'h0000;
      @(negedge clk); ld = 1'b0;
      cyc(50);
      wait_ctrl(4'b1101, "wait_tens_0");
`ifdef LEADING_ZERO_BLANK_EN
      check("lz_tens_zero", seg, 8'hFF);
`else
      check("lz_tens_zero", seg, 8'hC0);
`endif
      wait_ctrl(4'b1110, "wait_ones_0");
      check("ones_0", seg, 8'hC0);

      // Reset with a load pending: discarded silently, display returns to 0
      @(negedge clk); ld = 1'b1; din = 16'h0005;
      @(negedge clk); ld = 1'b0;
      wait_ctrl(4'b1101, "wait_tens_rst");
      @(negedge clk); ld = 1'b1; din = 16'h1111;
      @(negedge clk); ld = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      a0 = ack_seen;
      cyc(2); #3;
      check("post_reset_fs", fs, 1);
      check("post_reset_seg", seg, 8'hC0);
      cyc(30);
      check("post_reset_acks", ack_seen - a0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
